// File: rtl/out_port_alloc.sv
// rtl/out_port_alloc.sv - per-output wormhole allocator holding the arbiter grant for a whole packet
// Optional stall-release feature: PKT_TIMEOUT_EN.
module out_port_alloc #(
    parameter int IN_N        = 5,
    parameter int FLIT_W      = 32,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [IN_N-1:0]                             req_i,
    output logic [IN_N-1:0]                             arb_req_o,
    input  logic [((IN_N > 1) ? $clog2(IN_N) : 1)-1:0]  arb_grant_i,
    input  logic [IN_N*FLIT_W-1:0]                      data_i,
    input  logic [IN_N-1:0]                             valid_i,
    input  logic [IN_N-1:0]                             tail_i,
    input  logic                                        ready_i,
    output logic [FLIT_W-1:0]                           data_o,
    output logic                                        valid_o,
    output logic [IN_N-1:0]                             rd_o,
    output logic [((IN_N > 1) ? $clog2(IN_N) : 1)-1:0]  sel_o,
    output logic                                        locked_o,
    output logic [CNT_W-1:0]                            pkt_cnt_o,
    output logic                                        timeout_o
);

    localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [CNT_W-1:0]   r_pkt_cnt;

    logic               w_locked;
    logic               w_valid_sel;
    logic               w_tail_sel;
    logic [FLIT_W-1:0]  w_data_sel;
    logic               w_xfer;
    logic [IN_N-1:0]    w_rd;

    assign w_locked = (r_state == S_LOCKED);

    // Mux by comparison so out-of-range select codes simply produce zeros.
    always_comb begin
        w_valid_sel = 1'b0;
        w_tail_sel  = 1'b0;
        w_data_sel  = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (r_sel == i[SEL_W-1:0]) begin
                w_valid_sel = valid_i[i];
                w_tail_sel  = tail_i[i];
                w_data_sel  = data_i[i*FLIT_W +: FLIT_W];
            end
        end
    end

    assign w_xfer = w_locked & w_valid_sel & ready_i;

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < IN_N; i++) begin
            w_rd[i] = w_xfer & (r_sel == i[SEL_W-1:0]);
        end
    end

    assign arb_req_o = w_locked ? '0 : req_i;
    assign data_o    = w_data_sel;
    assign valid_o   = w_locked & w_valid_sel;
    assign rd_o      = w_rd;
    assign sel_o     = r_sel;
    assign locked_o  = w_locked;
    assign pkt_cnt_o = r_pkt_cnt;

`ifdef PKT_TIMEOUT_EN
    localparam int               STALL_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYC - 1);

    logic [STALL_W-1:0] r_stall;
    logic               r_timeout;

    assign timeout_o = r_timeout;
`else
    // Constant 0; the comparison only keeps TIMEOUT_CYC referenced in this build.
    assign timeout_o = (TIMEOUT_CYC < 0);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_pkt_cnt <= '0;
`ifdef PKT_TIMEOUT_EN
            r_stall   <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
`ifdef PKT_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (|req_i) begin
                        r_sel   <= arb_grant_i;
                        r_state <= S_LOCKED;
`ifdef PKT_TIMEOUT_EN
                        r_stall <= '0;
`endif
                    end
                end
                S_LOCKED: begin
                    if (w_xfer) begin
`ifdef PKT_TIMEOUT_EN
                        r_stall <= '0;
`endif
                        if (w_tail_sel) begin
                            r_state   <= S_IDLE;
                            r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        end
                    end
`ifdef PKT_TIMEOUT_EN
                    // Release on the edge that would bring the stall count to TIMEOUT_CYC.
                    else if (r_stall == STALL_LAST) begin
                        r_state   <= S_IDLE;
                        r_stall   <= '0;
                        r_timeout <= 1'b1;
                    end else begin
                        r_stall <= r_stall + 1'b1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_out_port_alloc.sv
// tb/tb_out_port_alloc.sv - directed scoreboard bench for out_port_alloc
module tb_out_port_alloc;

    localparam int IN_N   = 5;
    localparam int FLIT_W = 32;
    localparam int CNT_W  = 3;
    localparam int TO_CYC = 8;

    logic                    clk_i = 1'b0;
    logic                    rst_ni;
    logic [IN_N-1:0]         req_i;
    logic [IN_N-1:0]         arb_req_o;
    logic [2:0]              arb_grant_i;
    logic [IN_N*FLIT_W-1:0]  data_i;
    logic [IN_N-1:0]         valid_i;
    logic [IN_N-1:0]         tail_i;
    logic                    ready_i;
    logic [FLIT_W-1:0]       data_o;
    logic                    valid_o;
    logic [IN_N-1:0]         rd_o;
    logic [2:0]              sel_o;
    logic                    locked_o;
    logic [CNT_W-1:0]        pkt_cnt_o;
    logic                    timeout_o;

    always #5 clk_i = ~clk_i;

    out_port_alloc #(
        .IN_N        (IN_N),
        .FLIT_W      (FLIT_W),
        .CNT_W       (CNT_W),
        .TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .arb_req_o   (arb_req_o),
        .arb_grant_i (arb_grant_i),
        .data_i      (data_i),
        .valid_i     (valid_i),
        .tail_i      (tail_i),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .rd_o        (rd_o),
        .sel_o       (sel_o),
        .locked_o    (locked_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .timeout_o   (timeout_o)
    );

    // Round-robin arbiter model: search starts one past the last granted input.
    logic [2:0] rr_ptr;
    always_comb begin
        arb_grant_i = '0;
        for (int k = IN_N; k >= 1; k--) begin
            if (arb_req_o[(int'(rr_ptr) + k) % IN_N]) arb_grant_i = 3'((int'(rr_ptr) + k) % IN_N);
        end
    end
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rr_ptr <= 3'd4;
        else if (arb_req_o != '0) rr_ptr <= arb_grant_i;
    end

    typedef struct packed {
        logic [FLIT_W-1:0] d;
        logic              head;
        logic              tail;
    } flit_t;

    flit_t             bufq[IN_N][$];
    logic [FLIT_W-1:0] expq[IN_N][$];

    logic            rst_ctl;
    logic            ready_ctl;
    logic [IN_N-1:0] bubble;
    logic [IN_N-1:0] req_force;
    logic [IN_N-1:0] pend_rd;
    int              n_checks;
    int              n_errors;
    int              exp_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        logic [IN_N-1:0]        v_req, v_val, v_tail;
        logic [IN_N*FLIT_W-1:0] v_data;
        v_req  = req_force;
        v_val  = '0;
        v_tail = '0;
        v_data = '0;
        for (int i = 0; i < IN_N; i++) begin
            if (bufq[i].size() > 0) begin
                v_val[i]                  = ~bubble[i];
                v_tail[i]                 = bufq[i][0].tail;
                v_req[i]                  = v_req[i] | bufq[i][0].head;
                v_data[i*FLIT_W +: FLIT_W] = bufq[i][0].d;
            end
        end
        rst_ni  = rst_ctl;
        ready_i = ready_ctl;
        req_i   = v_req;
        valid_i = v_val;
        tail_i  = v_tail;
        data_i  = v_data;
    endtask

    // Advance one clock: pop what moved last cycle, drive, then score this cycle's transfer at negedge.
    task automatic cycle();
        int idx;
        @(posedge clk_i);
        #1;
        for (int i = 0; i < IN_N; i++) begin
            if (pend_rd[i] && bufq[i].size() > 0) void'(bufq[i].pop_front());
        end
        drive();
        @(negedge clk_i);
        pend_rd = rd_o;
        if (rd_o != '0) begin
            chk("rd_onehot", 32'($onehot(rd_o)), 32'd1);
            chk("rd_implies_locked", 32'(locked_o), 32'd1);
            idx = 0;
            for (int i = 0; i < IN_N; i++) if (rd_o[i]) idx = i;
            chk("sb_avail", 32'(expq[idx].size() > 0), 32'd1);
            if (expq[idx].size() > 0) begin
                chk("sb_data", data_o, expq[idx][0]);
                void'(expq[idx].pop_front());
            end
        end
    endtask

    task automatic load_pkt(input int src, input int len);
        flit_t f;
        for (int k = 0; k < len; k++) begin
            f.d    = $urandom;
            f.head = (k == 0);
            f.tail = (k == len - 1);
            bufq[src].push_back(f);
            expq[src].push_back(f.d);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int grants[4];
        int left;
        grants = '{0, 4, 0, 4};
        n_checks  = 0;
        n_errors  = 0;
        exp_cnt   = 0;
        pend_rd   = '0;
        rst_ctl   = 1'b0;
        ready_ctl = 1'b1;
        bubble    = '0;
        req_force = 5'b00110;
        drive();

        // Reset state with requests present
        cycle();
        cycle();
        chk("rst_arb_req", 32'(arb_req_o), 32'h06);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_locked", 32'(locked_o), 32'd0);
        chk("rst_cnt", 32'(pkt_cnt_o), 32'd0);
        chk("rst_sel", 32'(sel_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst_ctl   = 1'b1;
        req_force = '0;
        cycle();

        // 3-flit packet from input 2
        load_pkt(2, 3);
        cycle();
        chk("t2_idle_req", 32'(arb_req_o), 32'h04);
        chk("t2_idle_locked", 32'(locked_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("t2_locked", 32'(locked_o), 32'd1);
            chk("t2_sel", 32'(sel_o), 32'd2);
            chk("t2_rd", 32'(rd_o), 32'h04);
            chk("t2_arb_req_zero", 32'(arb_req_o), 32'd0);
        end
        exp_cnt++;
        cycle();
        chk("t2_unlocked", 32'(locked_o), 32'd0);
        chk("t2_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

        // Downstream stall mid-packet on input 1
        load_pkt(1, 3);
        cycle();
        cycle();
        chk("t3_first_rd", 32'(rd_o), 32'h02);
        ready_ctl = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("t3_stall_valid", 32'(valid_o), 32'd1);
            chk("t3_stall_rd", 32'(rd_o), 32'd0);
            chk("t3_stall_sel", 32'(sel_o), 32'd1);
        end
        ready_ctl = 1'b1;
        cycle();
        cycle();
        chk("t3_tail_rd", 32'(rd_o), 32'h02);
        exp_cnt++;
        cycle();
        chk("t3_unlocked", 32'(locked_o), 32'd0);
        chk("t3_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

        // Reset during the second flit of a packet
        load_pkt(3, 3);
        cycle();
        cycle();
        chk("t5_first_rd", 32'(rd_o), 32'h08);
        rst_ctl = 1'b0;
        cycle();
        chk("t5_rst_locked", 32'(locked_o), 32'd0);
        chk("t5_rst_rd", 32'(rd_o), 32'd0);
        chk("t5_rst_cnt", 32'(pkt_cnt_o), 32'd0);
        exp_cnt = 0;
        bufq[3].delete();
        expq[3].delete();
        rst_ctl = 1'b1;
        cycle();

        // Competing single-flit packets on inputs 0 and 4
        load_pkt(0, 1);
        load_pkt(0, 1);
        load_pkt(4, 1);
        load_pkt(4, 1);
        for (int p = 0; p < 4; p++) begin
            cycle();
            chk("t4_bubble_locked", 32'(locked_o), 32'd0);
            chk("t4_arb_req", 32'(arb_req_o), (p < 3) ? 32'h11 : 32'h10);
            cycle();
            chk("t4_locked", 32'(locked_o), 32'd1);
            chk("t4_grant", 32'(sel_o), 32'(grants[p]));
            chk("t4_arb_req_zero", 32'(arb_req_o), 32'd0);
            chk("t4_rd", 32'(rd_o), 32'(1 << grants[p]));
            exp_cnt++;
        end
        cycle();
        chk("t4_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

        // Long bubble on input 3
        load_pkt(3, 2);
        bubble = 5'b01000;
        cycle();
        chk("t6_idle", 32'(locked_o), 32'd0);
`ifdef PKT_TIMEOUT_EN
        for (int k = 0; k < TO_CYC; k++) begin
            cycle();
            chk("t6_held", 32'(locked_o), 32'd1);
            chk("t6_no_timeout", 32'(timeout_o), 32'd0);
            chk("t6_rd", 32'(rd_o), 32'd0);
        end
        cycle();
        chk("t6_released", 32'(locked_o), 32'd0);
        chk("t6_timeout_pulse", 32'(timeout_o), 32'd1);
        chk("t6_cnt_kept", 32'(pkt_cnt_o), 32'(exp_cnt));
        cycle();
        chk("t6_relock", 32'(locked_o), 32'd1);
        chk("t6_pulse_end", 32'(timeout_o), 32'd0);
`else
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("t6_held", 32'(locked_o), 32'd1);
            chk("t6_no_timeout", 32'(timeout_o), 32'd0);
            chk("t6_rd", 32'(rd_o), 32'd0);
        end
`endif
        bubble = '0;
        cycle();
        chk("t6_head_rd", 32'(rd_o), 32'h08);
        cycle();
        chk("t6_tail_rd", 32'(rd_o), 32'h08);
        exp_cnt++;
        cycle();
        chk("t6_done", 32'(locked_o), 32'd0);
        chk("t6_cnt", 32'(pkt_cnt_o), 32'(exp_cnt));

        // Counter wrap at 2^CNT_W
        load_pkt(2, 1);
        load_pkt(2, 1);
        load_pkt(2, 1);
        for (int k = 0; k < 5; k++) cycle();
        chk("wrap_pre", 32'(pkt_cnt_o), 32'd7);
        cycle();
        cycle();
        chk("wrap_zero", 32'(pkt_cnt_o), 32'd0);
        chk("wrap_idle", 32'(locked_o), 32'd0);

        left = 0;
        for (int i = 0; i < IN_N; i++) left += expq[i].size();
        chk("sb_drained", 32'(left), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
